// File: rtl/cdb_arbiter_pkg.sv
// Shared types and constants for the common-data-bus arbiter and its per-source queues.
package cdb_arbiter_pkg;

    localparam int NUM_SRC_DEFAULT = 3;
    localparam int SRC_ALU         = 0;
    localparam int SRC_ST          = 1;
    localparam int SRC_LD          = 2;
    localparam int ROB_TAG_W       = 6;

    typedef struct packed {
        logic                 valid;
        logic                 speculative;
        logic [31:0]          inst;
        logic [31:0]          NPC;
        logic [31:0]          value;
        logic [ROB_TAG_W-1:0] rob_tag;
    } EX_WR_PACKET;

    // Queue entries carry the full result packet; valid is always 1 while stored.
    typedef EX_WR_PACKET cdb_queue_entry_t;

endpackage

// File: rtl/cdb_src_queue.sv
// Per-source circular result FIFO with speculative squash/compaction and resolve.
module cdb_src_queue
    import cdb_arbiter_pkg::*;
#(
    parameter int QDEPTH = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  EX_WR_PACKET      enq_pkt,
    input  logic             kill,
    input  logic             resolve,
    input  logic             deq,
    output cdb_queue_entry_t head_pkt,
    output logic             eligible,
    output logic             full
);
    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = $clog2(QDEPTH + 1);

    cdb_queue_entry_t mem_reg  [QDEPTH];
    cdb_queue_entry_t mem_next [QDEPTH];
    logic [PW-1:0]    head_reg, head_next;
    logic [PW-1:0]    tail_reg, tail_next;
    logic [CW-1:0]    count_reg, count_next;
    logic             enq;
    cdb_queue_entry_t in_pkt;
    cdb_queue_entry_t e_pkt;
    int               idx;

    function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= QDEPTH) s = s - QDEPTH;
        return PW'(s);
    endfunction

    assign full     = (count_reg == CW'(QDEPTH));
    assign eligible = (count_reg != '0) && !(kill && mem_reg[head_reg].speculative);
    assign enq      = enq_pkt.valid && !full && !(kill && enq_pkt.speculative);

    always_comb begin
        head_pkt = mem_reg[head_reg];
        if (resolve && !kill) head_pkt.speculative = 1'b0;
    end

    always_comb begin
        mem_next   = mem_reg;
        head_next  = head_reg;
        tail_next  = tail_reg;
        count_next = count_reg;
        in_pkt     = enq_pkt;
        e_pkt      = '0;
        idx        = 0;
        if (resolve && !kill) in_pkt.speculative = 1'b0;
        if (kill) begin
            // Rebuild survivors from slot 0 so order is preserved and the count is exact.
            for (int k = 0; k < QDEPTH; k++) begin
                e_pkt = mem_reg[ptr_add(head_reg, k)];
                if (k < int'(count_reg) && !(k == 0 && deq) && !e_pkt.speculative) begin
                    if (idx < QDEPTH) mem_next[PW'(idx)] = e_pkt;
                    idx = idx + 1;
                end
            end
            if (enq) begin
                if (idx < QDEPTH) mem_next[PW'(idx)] = in_pkt;
                idx = idx + 1;
            end
            head_next  = '0;
            tail_next  = (idx >= QDEPTH) ? '0 : PW'(idx);
            count_next = CW'(idx);
        end else begin
            if (resolve) begin
                for (int k = 0; k < QDEPTH; k++) mem_next[PW'(k)].speculative = 1'b0;
            end
            if (deq) head_next = ptr_add(head_reg, 1);
            if (enq) begin
                mem_next[tail_reg] = in_pkt;
                tail_next          = ptr_add(tail_reg, 1);
            end
            count_next = count_reg + CW'(enq) - CW'(deq);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            mem_reg   <= mem_next;
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
        end
    end

    // A source must hold its result while its queue reports full.
    no_push_when_full_a: assert property (@(posedge clock) disable iff (reset)
        !(enq_pkt.valid && full));

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin common-data-bus arbiter over NUM_SRC result queues with registered broadcast.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_SRC = NUM_SRC_DEFAULT,
    parameter int QDEPTH  = 2
) (
    input  logic                       clock,
    input  logic                       reset,
    input  EX_WR_PACKET                src_in [NUM_SRC],
    input  logic                       kill,
    input  logic                       resolve,
    output logic [NUM_SRC-1:0]         src_full,
    output EX_WR_PACKET                cdb_out,
    output logic [$clog2(NUM_SRC)-1:0] grant_src
);
    localparam int GW = $clog2(NUM_SRC);

    cdb_queue_entry_t head_pkts [NUM_SRC];
    logic [NUM_SRC-1:0] eligible;
    logic [NUM_SRC-1:0] deq;
    logic [GW-1:0]      rr_reg;
    logic [GW-1:0]      pick_idx;
    logic               pick_valid;
    int                 cand;
    EX_WR_PACKET        cdb_next;

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_queue
            assign deq[gi] = pick_valid && (pick_idx == GW'(gi));
            cdb_src_queue #(.QDEPTH(QDEPTH)) u_queue (
                .clock    (clock),
                .reset    (reset),
                .enq_pkt  (src_in[gi]),
                .kill     (kill),
                .resolve  (resolve),
                .deq      (deq[gi]),
                .head_pkt (head_pkts[gi]),
                .eligible (eligible[gi]),
                .full     (src_full[gi])
            );
        end
    endgenerate

    // Scan begins at rr_reg and wraps; first eligible queue wins.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        for (int k = 0; k < NUM_SRC; k++) begin
            cand = int'(rr_reg) + k;
            if (cand >= NUM_SRC) cand = cand - NUM_SRC;
            if (!pick_valid && eligible[GW'(cand)]) begin
                pick_valid = 1'b1;
                pick_idx   = GW'(cand);
            end
        end
    end

    always_comb begin
        cdb_next = '0;
        if (pick_valid) begin
            cdb_next       = head_pkts[pick_idx];
            cdb_next.valid = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cdb_out   <= '0;
            grant_src <= '0;
            rr_reg    <= '0;
        end else begin
            cdb_out   <= cdb_next;
            grant_src <= pick_valid ? pick_idx : '0;
            if (pick_valid)
                rr_reg <= (int'(pick_idx) == NUM_SRC - 1) ? '0 : pick_idx + 1'b1;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench: a queue-based reference model predicts every broadcast cycle by cycle.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int NS = 3;
    localparam int QD = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic        kill;
    logic        resolve;
    EX_WR_PACKET src_in [NS];
    logic [NS-1:0] src_full;
    EX_WR_PACKET cdb_out;
    logic [1:0]  grant_src;

    cdb_arbiter #(.NUM_SRC(NS), .QDEPTH(QD)) dut (
        .clock     (clock),
        .reset     (reset),
        .src_in    (src_in),
        .kill      (kill),
        .resolve   (resolve),
        .src_full  (src_full),
        .cdb_out   (cdb_out),
        .grant_src (grant_src)
    );

    always #5 clock = ~clock;

    EX_WR_PACKET mq   [NS][$];   // model queue contents
    EX_WR_PACKET pend [NS][$];   // results each source still wants to deliver
    EX_WR_PACKET exp_pkt_q [$];
    int          exp_grant_q [$];
    int          rr = 0;
    int          checks = 0;
    int          failures = 0;
    EX_WR_PACKET mon_pkt;
    int          mon_g;

    function automatic EX_WR_PACKET mk(input int tag, input logic [31:0] val, input bit spec);
        EX_WR_PACKET p;
        p.valid       = 1'b1;
        p.speculative = spec;
        p.inst        = $urandom;
        p.NPC         = $urandom;
        p.value       = val;
        p.rob_tag     = 6'(tag);
        return p;
    endfunction

    // One clock cycle: present inputs, advance the model, queue the expected broadcast.
    task automatic step(input bit k, input bit r, input bit rst);
        bit          fullm [NS];
        bit          found;
        int          g;
        int          s;
        EX_WR_PACKET e;
        EX_WR_PACKET p;
        EX_WR_PACKET keep [$];
        for (int i = 0; i < NS; i++) begin
            fullm[i] = (mq[i].size() == QD);
            checks++;
            if (src_full[i] !== fullm[i]) begin
                failures++;
                $display("FAIL src_full[%0d] t=%0t got=%0b exp=%0b", i, $time, src_full[i], fullm[i]);
            end
        end
        reset   = rst;
        kill    = k;
        resolve = r;
        for (int i = 0; i < NS; i++) begin
            src_in[i] = '0;
            if (!rst && pend[i].size() > 0 && !fullm[i]) src_in[i] = pend[i].pop_front();
        end
        e = '0;
        g = 0;
        if (rst) begin
            for (int i = 0; i < NS; i++) mq[i] = {};
            rr = 0;
        end else begin
            found = 0;
            for (int n = 0; n < NS; n++) begin
                s = (rr + n) % NS;
                if (!found && mq[s].size() > 0 && !(k && mq[s][0].speculative)) begin
                    found = 1;
                    g = s;
                end
            end
            if (found) begin
                e = mq[g].pop_front();
                e.valid = 1'b1;
                if (r && !k) e.speculative = 1'b0;
                rr = (g + 1) % NS;
            end
            if (k) begin
                for (int i = 0; i < NS; i++) begin
                    keep = {};
                    for (int j = 0; j < mq[i].size(); j++)
                        if (!mq[i][j].speculative) keep.push_back(mq[i][j]);
                    mq[i] = keep;
                end
            end
            for (int i = 0; i < NS; i++) begin
                if (src_in[i].valid && !fullm[i] && !(k && src_in[i].speculative)) begin
                    p = src_in[i];
                    if (r && !k) p.speculative = 1'b0;
                    mq[i].push_back(p);
                end
            end
            if (r && !k) begin
                for (int i = 0; i < NS; i++)
                    for (int j = 0; j < mq[i].size(); j++) begin
                        p = mq[i][j];
                        p.speculative = 1'b0;
                        mq[i][j] = p;
                    end
            end
        end
        exp_pkt_q.push_back(e);
        exp_grant_q.push_back(g);
        @(posedge clock);
        #1;
    endtask

    // Monitor: every cycle the DUT presents one broadcast (possibly idle) to compare.
    initial begin
        forever begin
            @(negedge clock);
            if (exp_pkt_q.size() > 0) begin
                mon_pkt = exp_pkt_q.pop_front();
                mon_g   = exp_grant_q.pop_front();
                checks++;
                if (cdb_out !== mon_pkt || grant_src !== mon_g[1:0]) begin
                    failures++;
                    $display("FAIL cdb_out t=%0t got v=%0b s=%0b tag=%0d val=%h g=%0d exp v=%0b s=%0b tag=%0d val=%h g=%0d",
                             $time, cdb_out.valid, cdb_out.speculative, cdb_out.rob_tag, cdb_out.value, grant_src,
                             mon_pkt.valid, mon_pkt.speculative, mon_pkt.rob_tag, mon_pkt.value, mon_g);
                end else if (cdb_out.valid) begin
                    $display("cdb t=%0t src=%0d tag=%0d value=%h spec=%0b",
                             $time, grant_src, cdb_out.rob_tag, cdb_out.value, cdb_out.speculative);
                end
            end
        end
    end

    initial begin
        reset   = 1'b1;
        kill    = 1'b0;
        resolve = 1'b0;
        for (int i = 0; i < NS; i++) src_in[i] = '0;
        exp_pkt_q.push_back('0);
        exp_grant_q.push_back(0);
        @(posedge clock);
        #1;
        step(0, 0, 1);

        // single ALU result
        pend[SRC_ALU].push_back(mk(5, 32'h10, 0));
        repeat (3) step(0, 0, 0);

        // all sources at once
        for (int i = 0; i < NS; i++) pend[i].push_back(mk(10 + i, $urandom, 0));
        repeat (5) step(0, 0, 0);

        // ALU streaming alone
        for (int n = 0; n < 8; n++) begin
            pend[SRC_ALU].push_back(mk(20 + n, $urandom, 0));
            step(0, 0, 0);
        end
        repeat (2) step(0, 0, 0);

        // ALU competing with load every cycle: ALU queue fills and results are held
        for (int n = 0; n < 10; n++) begin
            pend[SRC_ALU].push_back(mk(32 + n, $urandom, 0));
            pend[SRC_LD].push_back(mk(48 + n, $urandom, 0));
            step(0, 0, 0);
        end
        repeat (20) step(0, 0, 0);

        // load queue [spec 3, nonspec 4] killed while store offers spec 6
        step(0, 0, 1);
        pend[SRC_ALU].push_back(mk(1, $urandom, 0));
        pend[SRC_LD].push_back(mk(3, $urandom, 1));
        step(0, 0, 0);
        pend[SRC_LD].push_back(mk(4, $urandom, 0));
        step(0, 0, 0);
        pend[SRC_ST].push_back(mk(6, $urandom, 1));
        step(1, 0, 0);
        repeat (3) step(0, 0, 0);

        // kill and resolve together
        pend[SRC_ALU].push_back(mk(30, $urandom, 1));
        pend[SRC_ST].push_back(mk(31, $urandom, 1));
        pend[SRC_LD].push_back(mk(32, $urandom, 0));
        step(0, 0, 0);
        step(1, 1, 0);
        repeat (4) step(0, 0, 0);

        // resolve then grant clears speculative bit
        pend[SRC_ST].push_back(mk(40, $urandom, 1));
        step(0, 0, 0);
        step(0, 1, 0);
        repeat (2) step(0, 0, 0);

        // reset mid-stream with full queues
        for (int i = 0; i < NS; i++)
            for (int n = 0; n < 4; n++) pend[i].push_back(mk(8 * i + n, $urandom, 0));
        repeat (3) step(0, 0, 0);
        step(0, 0, 1);
        repeat (2) step(0, 0, 0);

        // randomized traffic
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NS; i++)
                if (pend[i].size() < 3 && $urandom_range(0, 1) == 1)
                    pend[i].push_back(mk($urandom_range(0, 63), $urandom, $urandom_range(0, 2) == 0));
            step($urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 99) == 0);
        end
        repeat (20) step(0, 0, 0);

        repeat (2) @(negedge clock);
        #1;
        checks++;
        if (exp_pkt_q.size() != 0) begin
            failures++;
            $display("FAIL leftover_expectations got=%0d exp=0", exp_pkt_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
